// File: rtl/uart_rx_stage.sv
// 8N1 UART receiver with 16x oversampling, a two-flop input synchronizer and a
// single-entry holding register that reports overrun and framing errors.
module uart_rx_stage #(
  parameter logic [3:0] SAMPLE = 4'd7
) (
  input  logic       C,
  input  logic       R,
  input  logic       EN_16X,
  input  logic       SERIAL_IN,
  input  logic       READ,
  output logic [7:0] DOUT,
  output logic       DATA_PRESENT,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t     state_reg;
  logic [1:0] sync_reg;
  logic       rxs;
  logic [3:0] tick_reg;
  logic [3:0] tick_next;
  logic [2:0] bit_reg;
  logic [7:0] shift_reg;
  logic [7:0] dout_reg;
  logic       dp_reg;
  logic       ferr_reg;
  logic       ovr_reg;
  logic       sample_hit;
  logic       commit;
  logic       bad_stop;

  assign rxs        = sync_reg[1];
  assign tick_next  = tick_reg + 4'd1;
  assign sample_hit = EN_16X && (tick_next == SAMPLE);
  assign commit     = sample_hit && (state_reg == STOP) && rxs;
  assign bad_stop   = sample_hit && (state_reg == STOP) && !rxs;

  // tick_reg is the tick position inside the current bit cell, with the
  // start-detect tick as position 0; each later sample lands exactly one
  // cell (16 ticks) after the previous one.
  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= IDLE;
      sync_reg  <= 2'b11;
      tick_reg  <= 4'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      dout_reg  <= 8'h00;
      dp_reg    <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], SERIAL_IN};
      ferr_reg <= bad_stop;

      if (EN_16X) begin
        case (state_reg)
          IDLE: begin
            if (!rxs) begin
              state_reg <= START;
              tick_reg  <= 4'd0;
            end
          end
          START: begin
            tick_reg <= tick_next;
            if (tick_next == SAMPLE) begin
              if (!rxs) begin
                state_reg <= DATA;
                bit_reg   <= 3'd0;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
          DATA: begin
            tick_reg <= tick_next;
            if (tick_next == SAMPLE) begin
              shift_reg <= {rxs, shift_reg[7:1]};
              if (bit_reg == 3'd7) begin
                state_reg <= STOP;
              end else begin
                bit_reg <= bit_reg + 3'd1;
              end
            end
          end
          STOP: begin
            tick_reg <= tick_next;
            if (tick_next == SAMPLE) begin
              state_reg <= rxs ? IDLE : BREAK;
            end
          end
          BREAK: begin
            if (rxs) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end

      // A commit racing a READ keeps the byte present and leaves OVERRUN alone.
      if (commit) begin
        dout_reg <= shift_reg;
        dp_reg   <= 1'b1;
        if (dp_reg && !READ) begin
          ovr_reg <= 1'b1;
        end
      end else if (READ && dp_reg) begin
        dp_reg  <= 1'b0;
        ovr_reg <= 1'b0;
      end
    end
  end

  assign DOUT         = dout_reg;
  assign DATA_PRESENT = dp_reg;
  assign FRAME_ERR    = ferr_reg;
  assign OVERRUN      = ovr_reg;

endmodule

// File: tb/tb_uart_rx_stage.sv
// Self-checking bench for uart_rx_stage: directed scenarios plus randomized
// frames, all compared every cycle against a tick-counting reference model.
module tb_uart_rx_stage;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       EN_16X = 1'b0;
  logic       SERIAL_IN = 1'b1;
  logic       READ = 1'b0;
  logic [7:0] DOUT;
  logic       DATA_PRESENT;
  logic       FRAME_ERR;
  logic       OVERRUN;

  uart_rx_stage #(.SAMPLE(4'd7)) dut (
    .C            (C),
    .R            (R),
    .EN_16X       (EN_16X),
    .SERIAL_IN    (SERIAL_IN),
    .READ         (READ),
    .DOUT         (DOUT),
    .DATA_PRESENT (DATA_PRESENT),
    .FRAME_ERR    (FRAME_ERR),
    .OVERRUN      (OVERRUN)
  );

  always #5 C = ~C;

  int checks = 0;
  int failures = 0;
  int en_div = 1;
  int cyc = 0;
  bit read_on_commit = 1'b0;
  bit rand_read = 1'b0;
  bit armed = 1'b0;
  int fe_count = 0;

  // Reference model: line delay of two clocks, then a frame is described by
  // the number of oversample ticks since the start edge was seen.
  bit         m_d1 = 1'b1;
  bit         m_d2 = 1'b1;
  int         m_mode = 0;   // 0 idle, 1 inside a frame, 2 line held in break
  int         m_n = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_dout = 8'h00;
  bit         m_dp = 1'b0;
  bit         m_fe = 1'b0;
  bit         m_ovr = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model_step();
    bit rx;
    bit cm;
    bit bad;
    int k;
    cm  = 1'b0;
    bad = 1'b0;
    if (R) begin
      m_d1 = 1'b1; m_d2 = 1'b1; m_mode = 0; m_n = 0;
      m_dout = 8'h00; m_dp = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    end else begin
      rx   = m_d2;
      m_d2 = m_d1;
      m_d1 = SERIAL_IN;
      if (EN_16X) begin
        case (m_mode)
          0: if (!rx) begin m_mode = 1; m_n = 0; end
          1: begin
            m_n++;
            if (m_n == 7) begin
              if (rx) m_mode = 0;
            end else if (m_n > 7 && (m_n - 7) % 16 == 0) begin
              k = (m_n - 7) / 16;
              if (k <= 8) m_byte[k-1] = rx;
              else if (rx) begin cm = 1'b1; m_mode = 0; end
              else begin bad = 1'b1; m_mode = 2; end
            end
          end
          default: if (rx) m_mode = 0;
        endcase
      end
      m_fe = bad;
      if (cm) begin
        if (m_dp && !READ) m_ovr = 1'b1;
        m_dout = m_byte;
        m_dp   = 1'b1;
      end else if (READ && m_dp) begin
        m_dp  = 1'b0;
        m_ovr = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge C);
    model_step();
    armed = 1'b1;
  end

  initial forever begin
    @(negedge C);
    if (armed) begin
      chk("dout", DOUT, m_dout);
      chk("data_present", DATA_PRESENT, m_dp);
      chk("frame_err", FRAME_ERR, m_fe);
      chk("overrun", OVERRUN, m_ovr);
      if (FRAME_ERR === 1'b1) fe_count++;
    end
  end

  task automatic step(input logic ser, input logic rd);
    @(negedge C);
    SERIAL_IN = ser;
    EN_16X    = (cyc % en_div == 0);
    cyc++;
    READ = rd;
    if (rand_read && $urandom_range(0, 19) == 0) READ = 1'b1;
    if (read_on_commit && EN_16X && m_mode == 1 && m_n == 150) READ = 1'b1;
  endtask

  task automatic hold(input logic ser, input int n);
    int t;
    t = 0;
    while (t < n) begin
      step(ser, 1'b0);
      if (EN_16X) t++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    $display("frame byte=%02h stop=%0b en_div=%0d", b, stop_bit, en_div);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(b[i], 16);
    hold(stop_bit, 16);
  endtask

  initial begin
    int fe0;
    logic [7:0] rb;
    logic rs;
    repeat (3) step(1'b1, 1'b0);
    R = 1'b0;
    hold(1'b1, 10);
    chk("reset_dout", DOUT, 8'h00);
    chk("reset_dp", DATA_PRESENT, 1'b0);
    chk("reset_ovr", OVERRUN, 1'b0);

    send_frame(8'hA5, 1'b1);
    hold(1'b1, 4);
    chk("a5_dout", DOUT, 8'hA5);
    chk("a5_dp", DATA_PRESENT, 1'b1);
    chk("a5_ovr", OVERRUN, 1'b0);
    chk("a5_no_fe", fe_count, 0);
    step(1'b1, 1'b1);
    hold(1'b1, 2);
    chk("a5_read_dp", DATA_PRESENT, 1'b0);
    chk("a5_read_dout", DOUT, 8'hA5);

    $display("glitch low 4 ticks");
    hold(1'b0, 4);
    hold(1'b1, 30);
    chk("glitch_dp", DATA_PRESENT, 1'b0);
    chk("glitch_fe", fe_count, 0);

    fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 20);
    chk("bad_stop_fe_pulses", fe_count - fe0, 1);
    chk("bad_stop_dp", DATA_PRESENT, 1'b0);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 4);
    chk("after_break_dout", DOUT, 8'h81);
    chk("after_break_dp", DATA_PRESENT, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 2);

    send_frame(8'h11, 1'b1);
    hold(1'b1, 4);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 4);
    chk("ovr_dout", DOUT, 8'h22);
    chk("ovr_flag", OVERRUN, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("ovr_read_dp", DATA_PRESENT, 1'b0);
    chk("ovr_read_flag", OVERRUN, 1'b0);

    send_frame(8'hC3, 1'b1);
    hold(1'b1, 4);
    read_on_commit = 1'b1;
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 4);
    read_on_commit = 1'b0;
    chk("rc_dout", DOUT, 8'h5A);
    chk("rc_dp", DATA_PRESENT, 1'b1);
    chk("rc_ovr", OVERRUN, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    en_div = 4;
    send_frame(8'h77, 1'b1);
    hold(1'b1, 4);
    $display("frame byte=ff aborted by reset in bit 3");
    hold(1'b0, 16);
    hold(1'b1, 56);
    R = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    R = 1'b0;
    step(1'b1, 1'b0);
    chk("midreset_dout", DOUT, 8'h00);
    chk("midreset_dp", DATA_PRESENT, 1'b0);
    chk("midreset_ovr", OVERRUN, 1'b0);
    chk("midreset_fe", FRAME_ERR, 1'b0);
    hold(1'b1, 120);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, 4);
    chk("post_reset_dout", DOUT, 8'h0F);
    chk("post_reset_dp", DATA_PRESENT, 1'b1);

    rand_read = 1'b1;
    for (int f = 0; f < 14; f++) begin
      en_div = ($urandom_range(0, 1) == 0) ? 1 : 4;
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) begin
        $display("glitch low %0d ticks", 1 + f % 5);
        hold(1'b0, 1 + f % 5);
        hold(1'b1, 12);
      end
      send_frame(rb, rs);
      if (!rs) hold(1'b0, $urandom_range(0, 30));
      hold(1'b1, $urandom_range(2, 20));
    end
    rand_read = 1'b0;
    hold(1'b1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog: stimulus still running, required completion before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
